// File: rtl/uart_tx_param_if.sv
// Host-side handshake bundle for the parametrised UART transmitter.
// The master presents a word and its parity options; the slave answers with ready.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] d_in;
    logic                 valid;
    logic                 ready;
    logic                 p_en;
    logic                 p_sel;

    modport master (
        output d_in,
        output valid,
        output p_en,
        output p_sel,
        input  ready
    );

    modport slave (
        input  d_in,
        input  valid,
        input  p_en,
        input  p_sel,
        output ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// A one-word holding register lets the next frame start straight after the last stop bit.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_param_if.slave s_bus,
    output logic           tx,
    output logic           busy
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic even);
        return even ? (^data) : (~^data);
    endfunction

    state_t               r_state;
    logic [DIV_W-1:0]     r_div;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_hold_full;
    logic                 r_ready;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_pen;
    logic                 r_hold_psel;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_pen;

    state_t               w_state_nxt;
    logic [DIV_W-1:0]     w_div_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_shift_dn;
    logic                 w_tx_nxt;
    logic                 w_busy_nxt;
    logic                 w_load;
    logic                 w_hs;
    logic                 w_hold_full_nxt;
    logic                 w_bit_end;

    assign w_hs       = s_bus.valid & r_ready;
    assign w_bit_end  = (r_div == DIV_LAST);
    assign w_shift_dn = r_shift >> 1;
    // A write and a load on the same edge leave the holding register full.
    assign w_hold_full_nxt = w_hs | (r_hold_full & ~w_load);

    assign s_bus.ready = r_ready;
    assign tx          = r_tx;
    assign busy        = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_cnt       <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tx        <= w_tx_nxt;
            r_busy      <= w_busy_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_ready     <= ~w_hold_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
        if (w_hs) begin
            r_hold_data <= s_bus.d_in;
            r_hold_pen  <= s_bus.p_en;
            r_hold_psel <= s_bus.p_sel;
        end
        if (w_load) begin
            r_par <= parity_bit(r_hold_data, r_hold_psel);
            r_pen <= r_hold_pen;
        end
    end

    // tx/busy are computed for the next state so both outputs stay registered.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + 1'b1;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_div_nxt  = '0;
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_div_nxt = '0;
                    if (r_cnt == DATA_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_pen) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_shift_nxt = w_shift_dn;
                        w_tx_nxt    = w_shift_dn[0];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_div_nxt = '0;
                    if (r_cnt == STOP_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_hold_full) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_START;
                            w_tx_nxt    = 1'b0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_nxt = r_hold_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (one and two stop bits), a frame-decoding
// monitor per instance, and a queue of expected frames filled by the stimulus.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic tx0, busy0, tx1, busy1;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(rst), .s_bus(if0), .tx(tx0), .busy(busy0)
    );
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(rst), .s_bus(if1), .tx(tx1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         psel;
        bit         lat;
        bit         b2b;
        time        hs_t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mf[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic get_tx(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction
    function automatic logic get_busy(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_ready(input int idx);
        return (idx == 0) ? if0.ready : if1.ready;
    endfunction
    function automatic int qsz(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction
    function automatic void push(input int idx, input exp_t e);
        if (idx == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction
    function automatic exp_t pop(input int idx);
        if (idx == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction
    function automatic void flush(input int idx);
        if (idx == 0) q0.delete();
        else q1.delete();
    endfunction

    // Reference line level for bit slot 'slot' of a frame (slot 0 = start bit).
    function automatic logic exp_bit(input exp_t e, input int slot);
        int ones;
        bit odd_cnt;
        ones    = $countones(e.data);
        odd_cnt = (ones % 2) != 0;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return e.data[slot-1];
        if (e.pen && slot == 9) return e.psel ? odd_cnt : !odd_cnt;
        return 1'b1;
    endfunction

    task automatic drive(input int idx, input logic v, input logic [7:0] d,
                         input logic pen, input logic psel);
        if (idx == 0) begin
            if0.valid = v; if0.d_in = d; if0.p_en = pen; if0.p_sel = psel;
        end else begin
            if1.valid = v; if1.d_in = d; if1.p_en = pen; if1.p_sel = psel;
        end
    endtask

    task automatic send(input int idx, input logic [7:0] d, input bit pen, input bit psel,
                        input bit lat, input bit b2b);
        exp_t e;
        int   guard;
        @(negedge clk);
        drive(idx, 1'b1, d, pen, psel);
        guard = 0;
        while (get_ready(idx) !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            check($sformatf("ready_timeout_dut%0d", idx), 32'd0, 32'd1);
            drive(idx, 1'b0, 8'h00, 1'b0, 1'b0);
            return;
        end
        @(posedge clk);
        e = '{data: d, pen: pen, psel: psel, lat: lat, b2b: b2b, hs_t: $time};
        push(idx, e);
        #1;
        drive(idx, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        check($sformatf("ready_low_after_hs_dut%0d", idx), 32'(get_ready(idx)), 32'd0);
    endtask

    task automatic wait_done(input int idx);
        int g;
        g = 0;
        while ((qsz(idx) != 0 || mf[idx]) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check($sformatf("drain_timeout_dut%0d", idx), 32'd1, 32'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic monitor(input int idx, input int sb);
        exp_t       e;
        int         gap;
        int         len;
        int         bad;
        int         slot;
        logic [7:0] got;
        bit         aborted;
        time        t0;
        logic       eb;
        gap = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                flush(idx);
                mf[idx] = 1'b0;
                gap = 0;
                continue;
            end
            if (get_tx(idx) === 1'b1) begin
                if (gap == 0)
                    check($sformatf("busy_low_idle_dut%0d", idx), 32'(get_busy(idx)), 32'd0);
                gap++;
                continue;
            end
            if (qsz(idx) == 0) begin
                check($sformatf("unexpected_start_dut%0d", idx), 32'd1, 32'd0);
                while (get_tx(idx) !== 1'b1 && !rst) @(negedge clk);
                gap = 1;
                continue;
            end
            e       = pop(idx);
            mf[idx] = 1'b1;
            t0      = $time;
            len     = (1 + 8 + int'(e.pen) + sb) * CPB;
            bad     = 0;
            got     = '0;
            aborted = 1'b0;
            for (int s = 0; s < len; s++) begin
                if (s > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                slot = s / CPB;
                eb   = exp_bit(e, slot);
                if (get_tx(idx) !== eb || get_busy(idx) !== 1'b1) bad++;
                if (slot >= 1 && slot <= 8 && (s % CPB) == CPB / 2) got[slot-1] = get_tx(idx);
            end
            mf[idx] = 1'b0;
            if (aborted) begin
                flush(idx);
                gap = 0;
                continue;
            end
            check($sformatf("frame_bad_samples_dut%0d_%02h", idx, e.data), 32'(bad), 32'd0);
            check($sformatf("frame_data_dut%0d", idx), 32'(got), 32'(e.data));
            if (e.lat) check($sformatf("start_latency_dut%0d", idx), 32'(t0 - e.hs_t), 32'd15);
            if (e.b2b) check($sformatf("b2b_gap_dut%0d", idx), 32'(gap), 32'd0);
            gap = 0;
        end
    endtask

    initial begin
        fork
            monitor(0, 1);
            monitor(1, 2);
        join_none
    end

    initial begin
        int n;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_dut0", 32'({tx0, busy0, if0.ready}), 32'b101);
            check("idle_dut1", 32'({tx1, busy1, if1.ready}), 32'b101);
        end

        // Plain frame, then both parity senses
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(0);
        send(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_done(0);
        send(0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done(0);

        // Back-to-back pair
        send(0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(0);

        // Two stop bits
        send(1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(1);

        // Random bursts on both instances
        for (int b = 0; b < 5; b++) begin
            n = 1 + int'($urandom_range(3, 0));
            for (int i = 0; i < n; i++)
                send(0, 8'($urandom), 1'($urandom), 1'($urandom), i == 0, i > 0);
            wait_done(0);
        end
        for (int b = 0; b < 3; b++) begin
            n = 1 + int'($urandom_range(2, 0));
            for (int i = 0; i < n; i++)
                send(1, 8'($urandom), 1'($urandom), 1'($urandom), i == 0, i > 0);
            wait_done(1);
        end

        // Reset in the middle of a frame with a second word held
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        send(0, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_tx", 32'(tx0), 32'd1);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_ready", 32'(if0.ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({tx0, busy0}), 32'b10);
        end

        wait_done(0);
        wait_done(1);
        check("leftover_expected", 32'(qsz(0) + qsz(1)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
